nand_flash_target: RTL and testbench

- Device-side responder model for the NAND flash bus driven by the memory controller.
- Decodes CLE/ALE/wEn/rEn/cEn strobes and owns an internal word array plus a one-page page register.
- Executes page read, page program, block erase, read-status and reset commands.
- Reports ready/busy on `status` and drives the shared DIO bus only during read cycles.
- Serves as the bench-side flash target for controller verification and system simulation.

---
 rtl/nand_flash_target.sv | 247 ++++++++++++++++++++++++
 tb/tb_nand_flash_target.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_flash_target.sv
// Device-side NAND flash responder: strobe decode, command FSM, page register and word array.
// DIO is driven only for page-data and status reads; status reports ready (1) or busy (0).
module nand_flash_target #(
    parameter int AddressWidth = 16,
    parameter int DataWidth    = 16,
    parameter int PageWords    = 8,
    parameter int ReadLatency  = 4,
    parameter int ProgLatency  = 10,
    parameter int EraseLatency = 20
) (
    input  logic                 clk,
    input  logic                 Reset,
    inout  tri   [DataWidth-1:0] DIO,
    input  logic                 cEn,
    input  logic                 CLE,
    input  logic                 ALE,
    input  logic                 wEn,
    input  logic                 rEn,
    output logic                 status
);
    localparam int ColW   = $clog2(PageWords);
    localparam int MaxLat = (ProgLatency > EraseLatency)
                          ? ((ProgLatency > ReadLatency) ? ProgLatency : ReadLatency)
                          : ((EraseLatency > ReadLatency) ? EraseLatency : ReadLatency);
    localparam int CntW   = $clog2(MaxLat + 1);
    localparam int Words  = 2 ** AddressWidth;

    localparam logic [7:0] CmdReadSetup  = 8'h00;
    localparam logic [7:0] CmdReadConf   = 8'h30;
    localparam logic [7:0] CmdProgSetup  = 8'h80;
    localparam logic [7:0] CmdProgConf   = 8'h10;
    localparam logic [7:0] CmdEraseSetup = 8'h60;
    localparam logic [7:0] CmdEraseConf  = 8'hD0;
    localparam logic [7:0] CmdStatus     = 8'h70;
    localparam logic [7:0] CmdReset      = 8'hFF;

    typedef enum logic [2:0] {
        IDLE, ADDR_WAIT, CONFIRM_WAIT, PROG_DATA, BUSY, READ_OUT, STATUS_OUT
    } state_t;

    typedef enum logic [1:0] {OP_READ, OP_PROG, OP_ERASE} op_t;

    state_t                  state, state_n;
    op_t                     op, op_n;
    logic                    fail, fail_n;
    logic                    bstat, bstat_n;
    logic [AddressWidth-1:0] addr, addr_n;
    logic [ColW-1:0]         col, col_n;
    logic [CntW-1:0]         cnt, cnt_n;

    logic [DataWidth-1:0]    page_reg [PageWords];
    logic [DataWidth-1:0]    mem [Words];

    logic                    load_pg, prog_pg, erase_pg, pr_wr, pr_preset;
    logic [DataWidth-1:0]    dio_in, dout;
    logic [3:0]              strobes;
    logic                    illegal, cmd_cyc, addr_cyc, wr_cyc, rd_cyc, drive;
    logic [7:0]              cmd;
    logic [AddressWidth-1:0] page_base;

    assign dio_in    = DIO;
    assign cmd       = dio_in[7:0];
    assign strobes   = {CLE, ALE, wEn, rEn};
    // More than one strobe set: clearing the lowest set bit leaves something behind.
    assign illegal   = !cEn && (|(strobes & (strobes - 4'd1)));
    assign cmd_cyc   = !cEn && (strobes == 4'b1000);
    assign addr_cyc  = !cEn && (strobes == 4'b0100);
    assign wr_cyc    = !cEn && (strobes == 4'b0010);
    assign rd_cyc    = !cEn && (strobes == 4'b0001);
    assign page_base = {addr[AddressWidth-1:ColW], {ColW{1'b0}}};
    assign status    = (state != BUSY);

    always_comb begin
        state_n   = state;
        op_n      = op;
        fail_n    = fail;
        bstat_n   = bstat;
        addr_n    = addr;
        col_n     = col;
        cnt_n     = cnt;
        load_pg   = 1'b0;
        prog_pg   = 1'b0;
        erase_pg  = 1'b0;
        pr_wr     = 1'b0;
        pr_preset = 1'b0;

        if (illegal) fail_n = 1'b1;

        if (cmd_cyc && cmd == CmdReset) begin
            state_n = IDLE;
            fail_n  = 1'b0;
            bstat_n = 1'b0;
        end else begin
            case (state)
                IDLE, READ_OUT, STATUS_OUT: begin
                    if (cmd_cyc) begin
                        case (cmd)
                            CmdReadSetup: begin
                                state_n = ADDR_WAIT;
                                op_n    = OP_READ;
                                if (state == IDLE) fail_n = 1'b0;
                            end
                            CmdProgSetup: begin
                                state_n = ADDR_WAIT;
                                op_n    = OP_PROG;
                                if (state == IDLE) fail_n = 1'b0;
                            end
                            CmdEraseSetup: begin
                                state_n = ADDR_WAIT;
                                op_n    = OP_ERASE;
                                if (state == IDLE) fail_n = 1'b0;
                            end
                            CmdStatus: state_n = STATUS_OUT;
                            default:   fail_n  = 1'b1;
                        endcase
                    end else if (rd_cyc && state == READ_OUT) begin
                        col_n = col + 1'b1;
                    end
                end
                ADDR_WAIT: begin
                    if (addr_cyc) begin
                        addr_n = dio_in[AddressWidth-1:0];
                        col_n  = dio_in[ColW-1:0];
                        if (op == OP_PROG) begin
                            state_n   = PROG_DATA;
                            pr_preset = 1'b1;
                        end else begin
                            state_n = CONFIRM_WAIT;
                        end
                    end else if (cmd_cyc) begin
                        state_n = IDLE;
                        fail_n  = 1'b1;
                    end
                end
                PROG_DATA: begin
                    if (wr_cyc) begin
                        pr_wr = 1'b1;
                        col_n = col + 1'b1;
                    end else if (cmd_cyc) begin
                        if (cmd == CmdProgConf) begin
                            state_n = BUSY;
                            cnt_n   = CntW'(ProgLatency - 1);
                        end else begin
                            state_n = IDLE;
                            fail_n  = 1'b1;
                        end
                    end
                end
                CONFIRM_WAIT: begin
                    if (cmd_cyc) begin
                        if (op == OP_READ && cmd == CmdReadConf) begin
                            state_n = BUSY;
                            cnt_n   = CntW'(ReadLatency - 1);
                        end else if (op == OP_ERASE && cmd == CmdEraseConf) begin
                            state_n = BUSY;
                            cnt_n   = CntW'(EraseLatency - 1);
                        end else begin
                            state_n = IDLE;
                            fail_n  = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cmd_cyc && cmd == CmdStatus) bstat_n = 1'b1;
                    // Counter holds the remaining cycles minus one; zero means this edge completes.
                    if (cnt == '0) begin
                        bstat_n = 1'b0;
                        case (op)
                            OP_READ: begin
                                load_pg = 1'b1;
                                state_n = READ_OUT;
                                col_n   = addr[ColW-1:0];
                            end
                            OP_PROG: begin
                                prog_pg = 1'b1;
                                state_n = IDLE;
                            end
                            default: begin
                                erase_pg = 1'b1;
                                state_n  = IDLE;
                            end
                        endcase
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state <= IDLE;
            op    <= OP_READ;
            fail  <= 1'b0;
            bstat <= 1'b0;
            addr  <= '0;
            col   <= '0;
            cnt   <= '0;
            for (int unsigned i = 0; i < PageWords; i++) page_reg[i] <= '1;
        end else begin
            state <= state_n;
            op    <= op_n;
            fail  <= fail_n;
            bstat <= bstat_n;
            addr  <= addr_n;
            col   <= col_n;
            cnt   <= cnt_n;
            if (pr_preset) begin
                for (int unsigned i = 0; i < PageWords; i++) page_reg[i] <= '1;
            end else if (load_pg) begin
                for (int unsigned i = 0; i < PageWords; i++)
                    page_reg[i] <= mem[page_base + AddressWidth'(i)];
            end else if (pr_wr) begin
                page_reg[col] <= dio_in;
            end
        end
    end

    // Array is never reset; a reset on the completion edge suppresses the update.
    always_ff @(posedge clk) begin
        if (Reset) begin
            if (prog_pg) begin
                for (int unsigned i = 0; i < PageWords; i++)
                    mem[page_base + AddressWidth'(i)] <= mem[page_base + AddressWidth'(i)] & page_reg[i];
            end else if (erase_pg) begin
                for (int unsigned i = 0; i < PageWords; i++)
                    mem[page_base + AddressWidth'(i)] <= '1;
            end
        end
    end

    always_comb begin
        dout = '0;
        if (state == READ_OUT) begin
            dout = page_reg[col];
        end else begin
            dout[1] = fail;
            dout[0] = status;
        end
    end

    assign drive = rd_cyc && (state == READ_OUT || state == STATUS_OUT || (state == BUSY && bstat));
    assign DIO   = drive ? dout : 'z;

endmodule

// File: tb/tb_nand_flash_target.sv
// Bench for nand_flash_target: strobe/status vector table, directed multi-cycle sequences,
// and randomized program/read/erase traffic checked against a page-level array model.
module tb_nand_flash_target;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int PW = 8;

    logic          clk     = 1'b0;
    logic          Reset   = 1'b0;
    logic          cEn     = 1'b1;
    logic          CLE     = 1'b0;
    logic          ALE     = 1'b0;
    logic          wEn     = 1'b0;
    logic          rEn     = 1'b0;
    logic          dio_oe  = 1'b0;
    logic [DW-1:0] dio_drv = '0;
    logic          status;
    tri   [DW-1:0] DIO;

    int total = 0;
    int bad   = 0;

    assign DIO = dio_oe ? dio_drv : 'z;
    always #5 clk = ~clk;

    nand_flash_target #(
        .AddressWidth(AW), .DataWidth(DW), .PageWords(PW),
        .ReadLatency(4), .ProgLatency(10), .EraseLatency(20)
    ) dut (
        .clk(clk), .Reset(Reset), .DIO(DIO), .cEn(cEn), .CLE(CLE),
        .ALE(ALE), .wEn(wEn), .rEn(rEn), .status(status)
    );

    typedef struct {
        logic          cen, cle, ale, wen, ren;
        logic [DW-1:0] data;
        logic          exp_z;
        logic [DW-1:0] exp_dio;
        logic          exp_st;
    } vec_t;

    vec_t vt[$];
    logic [DW-1:0] model [int];

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic set_pins(input logic ce, input logic cle, input logic ale, input logic we,
                            input logic re, input logic [DW-1:0] d);
        @(negedge clk);
        cEn = ce; CLE = cle; ALE = ale; wEn = we; rEn = re;
        dio_drv = d;
        dio_oe  = ((int'(cle) + int'(ale) + int'(we)) == 1) && !re;
    endtask

    task automatic cmd(input logic [7:0] b);      set_pins(0, 1, 0, 0, 0, {8'h00, b}); endtask
    task automatic adr(input logic [DW-1:0] a);   set_pins(0, 0, 1, 0, 0, a);          endtask
    task automatic wr(input logic [DW-1:0] d);    set_pins(0, 0, 0, 1, 0, d);          endtask
    task automatic idle();                        set_pins(0, 0, 0, 0, 0, '0);         endtask

    task automatic rd(output logic [DW-1:0] v);
        set_pins(0, 0, 0, 0, 1, '0);
        #1 v = DIO;
    endtask

    // Counts busy cycles after a confirm; 200 means the target never came back.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            idle();
            #1;
            if (status === 1'b1) break;
            n++;
        end
    endtask

    task automatic do_erase(input logic [DW-1:0] a, input string nm);
        int n;
        cmd(8'h60); adr(a); cmd(8'hD0);
        wait_ready(n);
        check({nm, " erase busy"}, 16'(n), 16'd20);
    endtask

    task automatic do_prog(input logic [DW-1:0] a, input logic [DW-1:0] d[$], input string nm);
        int n;
        cmd(8'h80); adr(a);
        foreach (d[k]) wr(d[k]);
        cmd(8'h10);
        wait_ready(n);
        check({nm, " prog busy"}, 16'(n), 16'd10);
    endtask

    task automatic do_read(input logic [DW-1:0] a, input string nm);
        int n;
        cmd(8'h00); adr(a); cmd(8'h30);
        wait_ready(n);
        check({nm, " read busy"}, 16'(n), 16'd4);
    endtask

    task automatic read_expect(input logic [DW-1:0] exp[$], input string nm);
        logic [DW-1:0] v;
        foreach (exp[k]) begin
            rd(v);
            check($sformatf("%s word%0d", nm, k), v, exp[k]);
        end
    endtask

    initial begin
        int            n, kind, cnt;
        logic [DW-1:0] v, a, base;
        logic [2:0]    c;
        logic          dz;
        logic [DW-1:0] q[$];
        logic [DW-1:0] pr [PW];

        // Reset state
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        #1;
        dz = (DIO === 16'hzzzz);
        check("reset status", {15'b0, status}, 16'd1);
        check("reset dio z", {15'b0, dz}, 16'd1);

        // Strobe, bus-discipline and status vectors: {cen,cle,ale,wen,ren,data,exp_z,exp_dio,exp_st}
        vt.push_back('{1, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1});
        vt.push_back('{0, 1, 1, 0, 0, 16'h0070, 1, 16'h0000, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h0070, 0, 16'h0070, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 16'h0003, 1});
        vt.push_back('{1, 0, 0, 0, 1, 16'h0000, 1, 16'h0000, 1});
        vt.push_back('{0, 1, 0, 0, 1, 16'h0070, 1, 16'h0000, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 16'h0003, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h00FF, 0, 16'h00FF, 1});
        vt.push_back('{0, 0, 0, 0, 0, 16'h0000, 1, 16'h0000, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h0070, 0, 16'h0070, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 16'h0001, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h0055, 0, 16'h0055, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 16'h0003, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h00FF, 0, 16'h00FF, 1});
        vt.push_back('{0, 1, 0, 0, 0, 16'h0070, 0, 16'h0070, 1});
        vt.push_back('{0, 0, 0, 0, 1, 16'h0000, 0, 16'h0001, 1});

        for (int i = 0; i < vt.size(); i++) begin
            set_pins(vt[i].cen, vt[i].cle, vt[i].ale, vt[i].wen, vt[i].ren, vt[i].data);
            #1;
            dz = (DIO === 16'hzzzz);
            check($sformatf("vec%0d dio z", i), {15'b0, dz}, {15'b0, vt[i].exp_z});
            if (!vt[i].exp_z) check($sformatf("vec%0d dio", i), DIO, vt[i].exp_dio);
            check($sformatf("vec%0d status", i), {15'b0, status}, {15'b0, vt[i].exp_st});
        end

        // Program and read back, then column wrap
        do_erase(16'h0010, "prep");
        do_prog(16'h0010, '{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                           16'h5555, 16'h6666, 16'h7777, 16'h8888}, "p1");
        do_read(16'h0010, "r1");
        read_expect('{16'h1111, 16'h2222, 16'h3333, 16'h4444,
                      16'h5555, 16'h6666, 16'h7777, 16'h8888}, "r1");
        do_read(16'h0016, "wrap");
        read_expect('{16'h7777, 16'h8888, 16'h1111, 16'h2222}, "wrap");

        // Erase, then program-only-clears-bits
        do_erase(16'h0010, "e1");
        do_read(16'h0010, "e1");
        read_expect('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,
                      16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, "e1");
        do_prog(16'h0010, '{16'h0F0F}, "and1");
        do_prog(16'h0010, '{16'hF0F0}, "and2");
        do_read(16'h0010, "and");
        read_expect('{16'h0000, 16'hFFFF}, "and");

        // Status during busy, after completion, and after an illegal command
        cmd(8'h80); adr(16'h0011); wr(16'h1234); cmd(8'h10);
        idle(); idle(); cmd(8'h70);
        rd(v);
        check("status mid-prog", v, 16'h0000);
        wait_ready(n);
        check("prog remaining busy", 16'(n), 16'd6);
        cmd(8'h70); rd(v);
        check("status ready", v, 16'h0001);
        cmd(8'h55); cmd(8'h70); rd(v);
        check("status fail", v, 16'h0003);

        // Reset on busy cycle 5 of a program aborts it
        cmd(8'h80); adr(16'h0012); wr(16'h0000); cmd(8'h10);
        repeat (4) idle();
        idle(); Reset = 1'b0;
        idle(); Reset = 1'b1;
        #1 check("reset abort status", {15'b0, status}, 16'd1);
        do_read(16'h0012, "rabort");
        read_expect('{16'hFFFF}, "rabort");

        // 0xFF mid-erase aborts it and clears fail
        cmd(8'h55);
        cmd(8'h60); adr(16'h0010); cmd(8'hD0);
        repeat (7) idle();
        cmd(8'hFF);
        idle();
        #1 check("ff abort status", {15'b0, status}, 16'd1);
        cmd(8'h70); rd(v);
        check("ff abort fail clear", v, 16'h0001);
        do_read(16'h0010, "ffabort");
        read_expect('{16'h0000, 16'h1234, 16'hFFFF}, "ffabort");

        // Randomized traffic over pages 0x0100..0x011F against an array model
        for (int p = 0; p < 4; p++) begin
            do_erase(16'h0100 + 16'(p * PW), "rinit");
            for (int w = 0; w < PW; w++) model[32'h100 + p * PW + w] = 16'hFFFF;
        end
        for (int it = 0; it < 24; it++) begin
            kind = $urandom_range(0, 3);
            a    = 16'h0100 + 16'($urandom_range(0, 31));
            base = a & ~16'(PW - 1);
            c    = a[2:0];
            if (kind == 0) begin
                do_erase(a, $sformatf("rnd%0d", it));
                for (int w = 0; w < PW; w++) model[int'(base) + w] = 16'hFFFF;
            end else if (kind == 1) begin
                cnt = $urandom_range(1, 10);
                q.delete();
                for (int k = 0; k < PW; k++) pr[k] = 16'hFFFF;
                for (int k = 0; k < cnt; k++) begin
                    q.push_back(16'($urandom));
                    pr[(int'(c) + k) % PW] = q[k];
                end
                do_prog(a, q, $sformatf("rnd%0d", it));
                for (int w = 0; w < PW; w++) model[int'(base) + w] = model[int'(base) + w] & pr[w];
            end else begin
                cnt = $urandom_range(1, 12);
                q.delete();
                for (int k = 0; k < cnt; k++) q.push_back(model[int'(base) + ((int'(c) + k) % PW)]);
                do_read(a, $sformatf("rnd%0d", it));
                read_expect(q, $sformatf("rnd%0d", it));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
